alk_mdstep_seq: RTL
===================

# alk_mdstep_seq

Multiply/divide step sequencer for the DC615 ALK slice of the DPM. On a microcode start request it issues a programmed number of Q-register shift steps, all left (divide) or all right (multiply). Each step is driven onto the ALK's MUX/DQ control field so the DQ decoder asserts `q_shl_l` or `q_shr_l`. Between steps and when idle it drives a no-shift code. It reports busy, last-step and done status back to the microsequencer.

## Interface
Parameters:
- `CNT_W`, default 5: width of the step counter. Maximum step count is 2^CNT_W − 1.

Ports:
- `clk_h`  in  1: clock. Every flop samples on the rising edge.
- `reset_l`  in  1: asynchronous, active-low reset.
- `start_h`  in  1: start request. Sampled only in IDLE.
- `op_div_h`  in  1: operation, sampled with `start_h`. 1 = divide (shift left). 0 = multiply (shift right).
- `count_h`  in  CNT_W: number of shift steps, sampled with `start_h`.
- `stall_h`  in  1: microcode stall. Freezes the sequencer for the current cycle.
- `abort_h`  in  1: abandon the operation. Takes priority over stall.
- `mux_h`  out  4: ALK MUX field drive.
- `dq_h`  out  2: ALK DQ field drive.
- `step_h`  out  1: high in each cycle that performs a shift.
- `last_h`  out  1: high on the final shift step.
- `busy_h`  out  1: high in RUN and DONE.
- `done_h`  out  1: one-cycle completion pulse.
- `cnt_h`  out  CNT_W: remaining step count.

## Operation
Outputs are all registered. Reset values: `mux_h`=4'h0, `dq_h`=2'b00, `step_h`=0, `last_h`=0, `busy_h`=0, `done_h`=0, `cnt_h`=0. State after reset is IDLE.

Codes driven onto the ALK field:
- Shift: `mux_h`=4'h1. This is the DQ-shift group, where the decoder requires mux[2]=0 and mux[0]=1.
- Shift direction: `dq_h`={1'b0, ~op_div}. `dq_h[0]`=1 selects shift right; 0 selects shift left.
- No-shift: `mux_h`=4'h0, `dq_h`=2'b00.

States:
- IDLE, start_h=1 and count_h≠0: latch op and count, then go to RUN.
- IDLE, start_h=1 and count_h=0: go directly to DONE. No shift is issued.
- RUN, not stalled: emit the shift code with `step_h`=1 and decrement `cnt_h`.
  - If `cnt_h`==1 before the decrement: assert `last_h` and go to DONE next.
- RUN, stall_h=1: hold state and count. Drive the no-shift code with `step_h`=0. A stalled cycle is never a step.
- DONE: `done_h`=1 and no-shift code for exactly one cycle, then IDLE.
  - `stall_h` does not extend DONE.
- Any state except IDLE, abort_h=1: go to IDLE next cycle, clear `cnt_h`, drive the no-shift code. `done_h` is not pulsed.
- `start_h` is ignored outside IDLE. There is no queuing.

Width rule: `cnt_h` counts down from the latched value and never wraps below 0.

## Timing
- Start at edge N: the first shift code is visible after edge N+1. That is one cycle of latency. With no stall, K steps occupy cycles N+1…N+K, and `done_h` is high in cycle N+K+1.
- `busy_h` goes high the cycle after start is accepted and drops in the cycle after DONE. Back-to-back starts are accepted in that IDLE cycle. Minimum spacing is K+2 cycles.
- count=0: `done_h` is high in cycle N+1 and `busy_h` is high for that single cycle.
- Abort and stall in the same cycle: abort wins.
- Asserting `reset_l` mid-operation forces reset values immediately, without waiting for a clock edge. Deassertion is synchronized externally.

## Structure
- Shared package `alk_pkg` holds:
  - State encoding: IDLE=2'b00, RUN=2'b01, DONE=2'b10.
  - Constants `MUX_DQSHF`=4'h1, `MUX_NOSHF`=4'h0, `DQ_SHL`=2'b00, `DQ_SHR`=2'b01.
- Sub-module `alk_mdstep_cnt`: loadable, enabled down-counter with a synchronous clear and an `eq1` flag. The top holds the FSM and the output registers.

## Test plan
- Reset mid-RUN (count=5, after 2 steps), then pull `reset_l` low → all outputs return to reset values asynchronously; after release, state is IDLE.
- Multiply, count=4, no stall → 4 cycles of `mux_h`=1, `dq_h`=01, `step_h`=1; `last_h` on the 4th; `done_h` in cycle 5.
- Divide, count=3, `stall_h` high in cycles 2–3 → exactly 3 steps with `dq_h`=00; no-shift code during the stall; `done_h` in cycle 6.
- count=0 start → no `step_h`; `done_h`=1 in cycle 1.
- Abort after 2 of 6 steps, with `stall_h` high in the same cycle → IDLE next cycle, `cnt_h`=0, no `done_h`.
- `start_h` held high throughout, count=2 → restart accepted only in the IDLE cycle after DONE; periodic `done_h` every 4 cycles.

Source files
------------

// File: rtl/alk_pkg.sv
// Shared definitions for the ALK multiply/divide step sequencer:
// FSM state encoding and the MUX/DQ field codes seen by the DQ decoder.
package alk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam logic [3:0] MUX_DQSHF = 4'h1;
  localparam logic [3:0] MUX_NOSHF = 4'h0;
  localparam logic [1:0] DQ_SHL    = 2'b00;
  localparam logic [1:0] DQ_SHR    = 2'b01;

  // Divide shifts Q left, multiply shifts Q right.
  function automatic logic [1:0] dq_dir(input logic op_div);
    return op_div ? DQ_SHL : DQ_SHR;
  endfunction

endpackage

// File: rtl/alk_mdstep_cnt.sv
// Loadable down-counter for the remaining step count. Saturates at zero,
// clear beats load beats decrement; eq1 flags the final step.
module alk_mdstep_cnt #(
  parameter int CNT_W = 5
) (
  input  logic             clk_h,
  input  logic             reset_l,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             eq1
);

  always_ff @(posedge clk_h or negedge reset_l) begin
    if (!reset_l) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign eq1 = (cnt == CNT_W'(1));

endmodule

// File: rtl/alk_mdstep_seq.sv
// Multiply/divide Q-shift step sequencer. The FSM decides each cycle's action;
// every status and ALK field output is registered from that decision.
module alk_mdstep_seq
  import alk_pkg::*;
#(
  parameter int CNT_W = 5
) (
  input  logic             clk_h,
  input  logic             reset_l,
  input  logic             start_h,
  input  logic             op_div_h,
  input  logic [CNT_W-1:0] count_h,
  input  logic             stall_h,
  input  logic             abort_h,
  output logic [3:0]       mux_h,
  output logic [1:0]       dq_h,
  output logic             step_h,
  output logic             last_h,
  output logic             busy_h,
  output logic             done_h,
  output logic [CNT_W-1:0] cnt_h
);

  state_t     state_reg, state_next;
  logic       op_div_reg;
  logic       cnt_load, cnt_en, cnt_clr, cnt_eq1;
  logic [3:0] mux_reg, mux_next;
  logic [1:0] dq_reg, dq_next;
  logic       step_reg, step_next;
  logic       last_reg, last_next;
  logic       busy_reg, busy_next;
  logic       done_reg, done_next;

  alk_mdstep_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk_h    (clk_h),
    .reset_l  (reset_l),
    .clr      (cnt_clr),
    .load     (cnt_load),
    .load_val (count_h),
    .en       (cnt_en),
    .cnt      (cnt_h),
    .eq1      (cnt_eq1)
  );

  always_ff @(posedge clk_h or negedge reset_l) begin
    if (!reset_l) begin
      state_reg  <= ST_IDLE;
      op_div_reg <= 1'b0;
      mux_reg    <= MUX_NOSHF;
      dq_reg     <= DQ_SHL;
      step_reg   <= 1'b0;
      last_reg   <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      if (cnt_load) op_div_reg <= op_div_h;
      mux_reg    <= mux_next;
      dq_reg     <= dq_next;
      step_reg   <= step_next;
      last_reg   <= last_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_load   = 1'b0;
    cnt_en     = 1'b0;
    cnt_clr    = 1'b0;
    mux_next   = MUX_NOSHF;
    dq_next    = DQ_SHL;
    step_next  = 1'b0;
    last_next  = 1'b0;
    busy_next  = 1'b0;
    done_next  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start_h) begin
          cnt_load   = 1'b1;
          state_next = (count_h == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        // Abort outranks stall; a stalled cycle drives the no-shift code.
        if (abort_h) begin
          cnt_clr    = 1'b1;
          state_next = ST_IDLE;
        end else begin
          busy_next = 1'b1;
          if (!stall_h) begin
            cnt_en    = 1'b1;
            step_next = 1'b1;
            mux_next  = MUX_DQSHF;
            dq_next   = dq_dir(op_div_reg);
            last_next = cnt_eq1;
            if (cnt_eq1) state_next = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
        if (abort_h) begin
          cnt_clr = 1'b1;
        end else begin
          busy_next = 1'b1;
          done_next = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign mux_h  = mux_reg;
  assign dq_h   = dq_reg;
  assign step_h = step_reg;
  assign last_h = last_reg;
  assign busy_h = busy_reg;
  assign done_h = done_reg;

endmodule
